// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window generator: pixel, 3x3 window and FSM state.
// Optional build macro: SOBEL_WINDOW_ERR_EN (see sobel_window_gen).
package sobel_pkg;

    typedef logic [7:0] pixel_t;

    // Index [r][c]: r=0 oldest row, c=0 oldest column
    typedef logic [2:0][2:0][7:0] window_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } win_state_t;

endpackage : sobel_pkg

// File: rtl/sobel_window_gen_if.sv
// Pixel-stream / window bus between the feeder, sobel_window_gen and sobel_edge.
// frame_err exists only when SOBEL_WINDOW_ERR_EN is defined.
interface sobel_window_gen_if;
    import sobel_pkg::*;

    pixel_t  pixel_in;
    logic    pixel_valid;
    logic    frame_start;
    window_t comp_matrix;
    logic    sobel_en;
    logic    frame_done;
    logic    busy;
`ifdef SOBEL_WINDOW_ERR_EN
    logic    frame_err;
`endif

    modport master (
        output pixel_in, pixel_valid, frame_start,
        input  comp_matrix, sobel_en, frame_done, busy
`ifdef SOBEL_WINDOW_ERR_EN
        , input frame_err
`endif
    );

    modport slave (
        input  pixel_in, pixel_valid, frame_start,
        output comp_matrix, sobel_en, frame_done, busy
`ifdef SOBEL_WINDOW_ERR_EN
        , output frame_err
`endif
    );

endinterface : sobel_window_gen_if

// File: rtl/line_buffer.sv
// One image row of pixel storage: combinational read of the old value, synchronous write.
// Contents are not reset; every location is rewritten before it is consumed.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DEPTH = 640
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  pixel_t                   din,
    output pixel_t                   dout
);

    pixel_t r_mem [DEPTH];

    assign dout = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= din;
        end
    end

endmodule : line_buffer

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator feeding sobel_edge.
// Define SOBEL_WINDOW_ERR_EN to add the sticky frame_err protocol flag.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic               clk,
    input  logic               n_rst,
    sobel_window_gen_if.slave  sif
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    win_state_t    r_state;
    win_state_t    w_next_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] w_col_eff;
    logic [CW-1:0] w_col_next;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_eff;
    logic [RW-1:0] w_row_next;
    logic          w_restart;
    logic          w_accept;
    logic          w_last;
    logic          w_win;
    pixel_t        w_rd0;
    pixel_t        w_rd1;
    window_t       r_window;
    logic          r_sobel_en;
    logic          r_frame_done;
    logic          r_busy;

    // A frame_start pixel restarts the raster at (0,0) from any state
    always_comb begin
        w_restart  = sif.pixel_valid && sif.frame_start;
        w_accept   = sif.pixel_valid && ((r_state != IDLE) || sif.frame_start);
        w_col_eff  = w_restart ? '0 : r_col;
        w_row_eff  = w_restart ? '0 : r_row;
        w_last     = (w_row_eff == ROW_LAST) && (w_col_eff == COL_LAST);
        w_win      = (w_row_eff >= RW'(2)) && (w_col_eff >= CW'(2));
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_accept) begin
            if (w_col_eff == COL_LAST) begin
                w_col_next = '0;
                w_row_next = w_last ? '0 : w_row_eff + RW'(1);
            end else begin
                w_col_next = w_col_eff + CW'(1);
                w_row_next = w_row_eff;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_restart) w_next_state = FILL;
            end
            FILL: begin
                if (w_restart)                                 w_next_state = FILL;
                else if (w_accept && (w_row_next == RW'(2)))   w_next_state = STREAM;
            end
            STREAM: begin
                if (w_restart)                  w_next_state = FILL;
                else if (w_accept && w_last)    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // LB0 holds row-2, LB1 holds row-1; LB0 inherits LB1's old value as LB1 takes the new pixel
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk   (clk),
        .wr_en (w_accept),
        .addr  (w_col_eff),
        .din   (w_rd1),
        .dout  (w_rd0)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .wr_en (w_accept),
        .addr  (w_col_eff),
        .din   (sif.pixel_in),
        .dout  (w_rd1)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_window     <= '0;
            r_sobel_en   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_col        <= w_col_next;
            r_row        <= w_row_next;
            r_sobel_en   <= w_accept && w_win;
            r_frame_done <= w_accept && w_last;
            r_busy       <= (w_next_state != IDLE);
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_window[r][0] <= r_window[r][1];
                    r_window[r][1] <= r_window[r][2];
                end
                r_window[0][2] <= w_rd0;
                r_window[1][2] <= w_rd1;
                r_window[2][2] <= sif.pixel_in;
            end
        end
    end

    assign sif.comp_matrix = r_window;
    assign sif.sobel_en    = r_sobel_en;
    assign sif.frame_done  = r_frame_done;
    assign sif.busy        = r_busy;

`ifdef SOBEL_WINDOW_ERR_EN
    logic r_frame_err;

    // Sticky: restart while busy, or an orphan pixel while idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_frame_err <= 1'b0;
        end else if ((w_restart && r_busy) ||
                     (sif.pixel_valid && !sif.frame_start && (r_state == IDLE))) begin
            r_frame_err <= 1'b1;
        end
    end

    assign sif.frame_err = r_frame_err;
`endif

endmodule : sobel_window_gen

// File: tb/tb_sobel_window_gen.sv
// Directed/randomized bench for sobel_window_gen on a 4x4 image against a raster-array model.
// Also checks frame_err when built with SOBEL_WINDOW_ERR_EN.
module tb_sobel_window_gen;
    import sobel_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk;
    logic n_rst;

    sobel_window_gen_if u_if ();

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .sif   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      n_checks;
    int      n_errors;
    // Reference model: the current frame as a raster array plus a frame-progress index
    pixel_t  img [N];
    bit      m_in_frame;
    int      m_idx;
    bit      m_err;
    bit      m_win_held;
    window_t m_last_win;
    int      obs_win;
    int      obs_done;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic window_t neighbourhood(input int r, input int c);
        window_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[(r - 2 + i) * W + (c - 2 + j)];
        return w;
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_idx      = 0;
        m_err      = 1'b0;
        m_win_held = 1'b0;
    endtask

    // Drive one cycle, predict, then check outputs #1 after the edge
    task automatic step(input bit v, input bit fs, input pixel_t pix);
        bit exp_en;
        bit exp_done;
        exp_en   = 1'b0;
        exp_done = 1'b0;
        u_if.pixel_valid = v;
        u_if.frame_start = fs;
        u_if.pixel_in    = pix;
        if (v) begin
            if (fs) begin
                if (m_in_frame) m_err = 1'b1;
                m_in_frame = 1'b1;
                m_idx      = 0;
            end else if (!m_in_frame) begin
                m_err = 1'b1;
            end
            if (m_in_frame) begin
                img[m_idx] = pix;
                if ((m_idx / W) >= 2 && (m_idx % W) >= 2) begin
                    exp_en     = 1'b1;
                    m_last_win = neighbourhood(m_idx / W, m_idx % W);
                    m_win_held = 1'b1;
                end else begin
                    m_win_held = 1'b0;
                end
                if (m_idx == N - 1) begin
                    exp_done   = 1'b1;
                    m_in_frame = 1'b0;
                end
                m_idx++;
            end
        end
        @(posedge clk);
        #1;
        if (u_if.sobel_en === 1'b1)   obs_win++;
        if (u_if.frame_done === 1'b1) obs_done++;
        chk("sobel_en", 72'(u_if.sobel_en), 72'(exp_en));
        chk("frame_done", 72'(u_if.frame_done), 72'(exp_done));
        chk("busy", 72'(u_if.busy), 72'(m_in_frame));
        if (m_win_held) chk("comp_matrix", u_if.comp_matrix, m_last_win);
`ifdef SOBEL_WINDOW_ERR_EN
        chk("frame_err", 72'(u_if.frame_err), 72'(m_err));
`endif
    endtask

    task automatic random_frame(input bit gaps);
        for (int i = 0; i < N; i++) begin
            step(1'b1, i == 0, pixel_t'($urandom));
            if (gaps) step(1'b0, 1'b0, pixel_t'($urandom));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_comp_matrix"}, u_if.comp_matrix, 72'd0);
        chk({tag, "_sobel_en"}, 72'(u_if.sobel_en), 72'd0);
        chk({tag, "_frame_done"}, 72'(u_if.frame_done), 72'd0);
        chk({tag, "_busy"}, 72'(u_if.busy), 72'd0);
    endtask

    initial begin
        window_t fw;
        n_checks = 0;
        n_errors = 0;
        obs_win  = 0;
        obs_done = 0;
        model_reset();
        n_rst = 1'b0;
        u_if.pixel_valid = 1'b0;
        u_if.frame_start = 1'b0;
        u_if.pixel_in    = '0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            u_if.pixel_valid = 1'($urandom);
            u_if.frame_start = 1'($urandom);
            u_if.pixel_in    = pixel_t'($urandom);
            @(posedge clk);
            #1;
            chk_outputs_zero("in_reset");
        end
        n_rst = 1'b1;

        // Orphan pixels in IDLE are dropped
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, pixel_t'($urandom));
        chk("orphan_pulses", 72'(obs_win), 72'd0);

        // Raster-index frame at full rate
        obs_win  = 0;
        obs_done = 0;
        for (int i = 0; i <= 10; i++) step(1'b1, i == 0, pixel_t'(i));
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                fw[i][j] = pixel_t'(i * 4 + j);
        chk("first_window", u_if.comp_matrix, fw);
        for (int i = 11; i < N; i++) step(1'b1, 1'b0, pixel_t'(i));
        step(1'b0, 1'b0, 8'h00);
        chk("raster_pulses", 72'(obs_win), 72'd4);
        chk("raster_done", 72'(obs_done), 72'd1);

        // Half-rate frame with gaps
        obs_win  = 0;
        random_frame(1'b1);
        chk("gap_pulses", 72'(obs_win), 72'd4);

        // Two back-to-back frames
        obs_win  = 0;
        obs_done = 0;
        random_frame(1'b0);
        random_frame(1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("b2b_pulses", 72'(obs_win), 72'd8);
        chk("b2b_done", 72'(obs_done), 72'd2);

        // Abort at pixel 6 by re-asserting frame_start
        obs_win  = 0;
        obs_done = 0;
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, pixel_t'($urandom));
        random_frame(1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_pulses", 72'(obs_win), 72'd4);
        chk("abort_done", 72'(obs_done), 72'd1);

        // Asynchronous reset after pixel 9
        for (int i = 0; i <= 9; i++) step(1'b1, i == 0, pixel_t'($urandom));
        u_if.pixel_valid = 1'b0;
        u_if.frame_start = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        obs_win  = 0;
        obs_done = 0;
        random_frame(1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("post_reset_pulses", 72'(obs_win), 72'd4);
        chk("post_reset_done", 72'(obs_done), 72'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sobel_window_gen
